p405s_dcu_plb_wr_ctl: RTL

P405S_DCU_PLB_WR_CTL -- requirements
Module: p405s_dcu_plb_wr_ctl

---
 rtl/p405s_dcu_plb_wr_ctl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/p405s_dcu_plb_wr_ctl.sv
// PLB write-data controller for the DCU: sequences store/line-buffer data into the PLB write data register.
// Optional low-to-high word mirroring for single FDR transfers is enabled by defining P405S_DCU_PLB_WR_MIRROR_EN.
//
// state  | meaning
// IDLE   | waiting for an accepted write request
// LOAD   | loading byte lanes of the write data register
// MIRROR | copying the low word into the high half (single FDR low-word transfer)
// XFER   | waiting for the PLB write data acknowledge
// DONE   | one-cycle completion
`timescale 1ns/1ps

module p405s_dcu_plb_wr_ctl (
  input  logic       CB,
  input  logic       resetN,
  input  logic       sampleCycle,
  input  logic       wrReq,
  input  logic       wrSrcSDP,
  input  logic       wrLine,
  input  logic       wrWordLo,
  input  logic [7:0] wrBE,
  input  logic       PLB_dcuWrDAck,
  input  logic       wrAbort,
  output logic       wrAck,
  output logic [3:0] PLBDR_E2,
  output logic [3:0] PLBDR_hiMuxSel,
  output logic       SDP_FDR_muxSel,
  output logic       sampleCycleL2,
  output logic [1:0] fdrRdIdx,
  output logic       DCU_plbWrBusy,
  output logic       wrDone
);

`ifdef P405S_DCU_PLB_WR_MIRROR_EN
  localparam bit MIRROR_EN = 1'b1;
`else
  localparam bit MIRROR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_MIRROR = 3'd2,
    S_XFER   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       sample_l2_q;
  logic       src_q, src_d;
  logic       line_q, line_d;
  logic       wordlo_q, wordlo_d;
  logic [7:0] be_q, be_d;
  logic [1:0] beat_q, beat_d;
  logic [1:0] idx_q, idx_d;

  logic       accept;
  logic       mirror_need;
  logic [3:0] lane_en;
  logic [3:0] e2;

  always_ff @(posedge CB or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      sample_l2_q <= 1'b0;
      src_q       <= 1'b0;
      line_q      <= 1'b0;
      wordlo_q    <= 1'b0;
      be_q        <= 8'h00;
      beat_q      <= 2'd0;
      idx_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      sample_l2_q <= sampleCycle;
      src_q       <= src_d;
      line_q      <= line_d;
      wordlo_q    <= wordlo_d;
      be_q        <= be_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
    end
  end

  // A single transfer only loads the lanes touched by either word of the doubleword.
  assign lane_en     = line_q ? 4'b1111 : (be_q[3:0] | be_q[7:4]);
  assign mirror_need = MIRROR_EN && !line_q && !src_q && wordlo_q;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    line_d   = line_q;
    wordlo_d = wordlo_q;
    be_d     = be_q;
    beat_d   = beat_q;
    idx_d    = idx_q;
    accept   = 1'b0;
    e2       = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (wrReq && sample_l2_q) begin
          accept   = 1'b1;
          src_d    = wrSrcSDP;
          line_d   = wrLine;
          wordlo_d = wrWordLo;
          be_d     = wrBE;
          beat_d   = 2'd0;
          idx_d    = 2'd0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        e2 = lane_en;
        if (sample_l2_q) begin
          state_d = mirror_need ? S_MIRROR : S_XFER;
        end
      end
      S_MIRROR: begin
        e2 = lane_en;
        if (sample_l2_q) begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (PLB_dcuWrDAck) begin
          if (line_q && (beat_q < 2'd3)) begin
            beat_d  = beat_q + 2'd1;
            idx_d   = idx_q + 2'd1;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a coincident acknowledge.
    if (wrAbort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      beat_d  = beat_q;
      idx_d   = idx_q;
    end
  end

  assign wrAck          = accept;
  assign PLBDR_E2       = e2;
  assign SDP_FDR_muxSel = (state_q != S_IDLE) && src_q;
  assign sampleCycleL2  = sample_l2_q;
  assign fdrRdIdx       = idx_q;
  assign DCU_plbWrBusy  = (state_q != S_IDLE);
  assign wrDone         = (state_q == S_DONE);

`ifdef P405S_DCU_PLB_WR_MIRROR_EN
  assign PLBDR_hiMuxSel = (state_q == S_MIRROR) ? 4'b1111 : 4'b0000;
`else
  assign PLBDR_hiMuxSel = 4'b0000;
`endif

endmodule
